sim_ram_req_ctrl: RTL and testbench

- Request/response front end sitting directly upstream of the simulation RAM model; converts a valid/ready bus with byte enables into the RAM's rd_en/wr_en bank ports.
- Performs read-modify-write for partial byte-enable writes, since the RAM writes whole banks only.
- Never issues a read and a write in the same cycle, so the RAM's same-address conflict assertion cannot fire.
- Buffers responses in a small FIFO so the consumer can apply backpressure.

---
 rtl/sim_ram_req_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sim_ram_req_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ram_req_ctrl.sv
// Valid/ready request front end for the simulation RAM: bank-granular RAM ports,
// read-modify-write for partial byte enables, and a small response FIFO.
module sim_ram_req_ctrl #(
   parameter int DATA_SIZE  = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_DEPTH = 2,
   localparam int DATA_WIDTH = 8 * DATA_SIZE,
   localparam int ADDR_START = $clog2(DATA_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   input  logic [DATA_SIZE-1:0]             req_be,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [DATA_WIDTH-1:0]            resp_rdata,
   output logic                             resp_err,
   output logic                             ram_rd_en,
   output logic [ADDR_WIDTH-ADDR_START-1:0] ram_rd_addr,
   output logic                             ram_wr_en,
   output logic [ADDR_WIDTH-ADDR_START-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0]            ram_wr_data,
   input  logic [DATA_WIDTH-1:0]            ram_rd_data
);

   localparam int BANK_W = ADDR_WIDTH - ADDR_START;
   localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ADDR_START) - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT} state_t;

   state_t                r_state;
   logic [BANK_W-1:0]     r_bank;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_SIZE-1:0]  r_be;

   logic [DATA_WIDTH-1:0] r_fifo_data [RESP_DEPTH];
   logic                  r_fifo_err  [RESP_DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;

   logic                  w_accept;
   logic                  w_misaligned;
   logic                  w_full_be;
   logic                  w_zero_be;
   logic [BANK_W-1:0]     w_req_bank;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic                  w_push_err;
   logic [DATA_WIDTH-1:0] w_merge;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit rule: a request is taken only when the FIFO can hold its response.
   assign req_ready    = (r_state == IDLE) && (r_count != CNT_W'(RESP_DEPTH));
   assign w_accept     = req_valid && req_ready;
   assign w_misaligned = |(req_addr & ALIGN_MASK);
   assign w_full_be    = &req_be;
   assign w_zero_be    = ~|req_be;
   assign w_req_bank   = req_addr[ADDR_WIDTH-1:ADDR_START];

   always_comb begin
      w_merge = '0;
      for (int unsigned i = 0; i < DATA_SIZE; i++) begin
         w_merge[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : ram_rd_data[8*i +: 8];
      end
   end

   always_comb begin
      ram_rd_en   = 1'b0;
      ram_wr_en   = 1'b0;
      ram_rd_addr = w_req_bank;
      ram_wr_addr = w_req_bank;
      ram_wr_data = req_wdata;
      w_push      = 1'b0;
      w_push_data = '0;
      w_push_err  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_misaligned) begin
                  w_push     = 1'b1;
                  w_push_err = 1'b1;
               end else if (!req_write) begin
                  ram_rd_en = 1'b1;
               end else if (w_full_be) begin
                  ram_wr_en = 1'b1;
                  w_push    = 1'b1;
               end else if (w_zero_be) begin
                  w_push = 1'b1;
               end else begin
                  ram_rd_en = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            w_push      = 1'b1;
            w_push_data = ram_rd_data;
         end
         RMW_WAIT: begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = r_bank;
            ram_wr_data = w_merge;
            w_push      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_bank  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && !w_misaligned &&
                   (!req_write || (!w_full_be && !w_zero_be))) begin
                  r_bank  <= w_req_bank;
                  r_wdata <= req_wdata;
                  r_be    <= req_be;
                  r_state <= req_write ? RMW_WAIT : RD_WAIT;
               end
            end
            RD_WAIT:  r_state <= IDLE;
            RMW_WAIT: r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase
      end
   end

   assign resp_valid = (r_count != '0);
   assign w_pop      = resp_valid && resp_ready;
   assign resp_rdata = resp_valid ? r_fifo_data[r_rptr] : '0;
   assign resp_err   = resp_valid && r_fifo_err[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_err[i]  <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= w_push_data;
            r_fifo_err[r_wptr]  <= w_push_err;
            r_wptr              <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_sim_ram_req_ctrl.sv
// Directed bench for sim_ram_req_ctrl with a RAM model, a shadow memory and a
// response scoreboard checked whenever the consumer pops the FIFO head.
module tb_sim_ram_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_rd_en;
   logic [5:0]  ram_rd_addr;
   logic        ram_wr_en;
   logic [5:0]  ram_wr_addr;
   logic [31:0] ram_wr_data;
   logic [31:0] ram_rd_data = '0;

   logic [31:0] mem    [64] = '{default: 32'h0};
   logic [31:0] shadow [64] = '{default: 32'h0};

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } resp_t;
   resp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sim_ram_req_ctrl #(.DATA_SIZE(4), .ADDR_WIDTH(8), .RESP_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_data(ram_rd_data)
   );

   // Simulation RAM: registered read data, whole-bank writes.
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic to_neg();
      resp_t e;
      @(negedge clk);
      chk("rd_wr_overlap", {31'b0, ram_rd_en & ram_wr_en}, 32'd0);
      if (resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.d);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.e});
         end
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         to_neg();
         to_pos();
      end
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic o_rd, output logic o_wr,
                        output logic [5:0] o_rda, output logic [5:0] o_wra,
                        output logic [31:0] o_wrd, output int o_wait);
      resp_t       e;
      logic [31:0] m;
      logic        done;
      done = 1'b0;
      o_rd = 1'b0; o_wr = 1'b0; o_rda = '0; o_wra = '0; o_wrd = '0; o_wait = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      for (int i = 0; i < 20 && !done; i++) begin
         to_neg();
         if (req_ready) begin
            done  = 1'b1;
            o_rd  = ram_rd_en;  o_wr  = ram_wr_en;
            o_rda = ram_rd_addr; o_wra = ram_wr_addr; o_wrd = ram_wr_data;
            o_wait = i;
            if (a[1:0] != 2'b00) begin
               e = '{d: 32'h0, e: 1'b1};
            end else if (!w) begin
               e = '{d: shadow[a[7:2]], e: 1'b0};
            end else begin
               m = shadow[a[7:2]];
               for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
               shadow[a[7:2]] = m;
               e = '{d: 32'h0, e: 1'b0};
            end
            exp_q.push_back(e);
         end
         to_pos();
      end
      req_valid = 1'b0;
      chk("req_accept_timeout", {31'b0, done}, 32'd1);
   endtask

   initial begin
      logic        rd, wr;
      logic [5:0]  rda, wra;
      logic [31:0] wrd;
      int          wt;

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; resp_ready = 1'b1;
      to_pos();
      to_neg();
      chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_err", {31'b0, resp_err}, 32'd0);
      chk("reset_rd_en", {31'b0, ram_rd_en}, 32'd0);
      chk("reset_wr_en", {31'b0, ram_wr_en}, 32'd0);
      to_pos();
      rst = 1'b0;
      idle(1);
      chk("idle_rd_en", {31'b0, ram_rd_en}, 32'd0);

      // Full write then read at 0x10
      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, wr, rda, wra, wrd, wt);
      chk("full_wr_en", {31'b0, wr}, 32'd1);
      chk("full_rd_en", {31'b0, rd}, 32'd0);
      chk("full_wr_addr", {26'b0, wra}, 32'd4);
      chk("full_wr_data", wrd, 32'hDEADBEEF);
      to_neg(); chk("full_lat1_valid", {31'b0, resp_valid}, 32'd1); to_pos();
      issue(1'b0, 8'h10, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      chk("rd_rd_en", {31'b0, rd}, 32'd1);
      chk("rd_wr_en", {31'b0, wr}, 32'd0);
      chk("rd_addr", {26'b0, rda}, 32'd4);
      to_neg(); chk("rd_lat1_valid", {31'b0, resp_valid}, 32'd0); to_pos();
      to_neg(); chk("rd_lat2_valid", {31'b0, resp_valid}, 32'd1); to_pos();

      // Partial write: low byte only
      issue(1'b1, 8'h10, 32'h000000AA, 4'b0001, rd, wr, rda, wra, wrd, wt);
      chk("rmw_rd_en", {31'b0, rd}, 32'd1);
      chk("rmw_rd_wr_en", {31'b0, wr}, 32'd0);
      chk("rmw_rd_addr", {26'b0, rda}, 32'd4);
      to_neg();
      chk("rmw_wr_en", {31'b0, ram_wr_en}, 32'd1);
      chk("rmw_wr_rd_en", {31'b0, ram_rd_en}, 32'd0);
      chk("rmw_wr_addr", {26'b0, ram_wr_addr}, 32'd4);
      chk("rmw_wr_data", ram_wr_data, 32'hDEADBEAA);
      chk("rmw_lat1_valid", {31'b0, resp_valid}, 32'd0);
      to_pos();
      to_neg(); chk("rmw_lat2_valid", {31'b0, resp_valid}, 32'd1); to_pos();
      issue(1'b0, 8'h10, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      idle(3);

      // Misaligned read
      issue(1'b0, 8'h13, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      chk("err_rd_en", {31'b0, rd}, 32'd0);
      chk("err_wr_en", {31'b0, wr}, 32'd0);
      to_neg(); chk("err_lat1_valid", {31'b0, resp_valid}, 32'd1); to_pos();
      idle(2);

      // Backpressure: FIFO fills after two acks, credit returns after one pop
      resp_ready = 1'b0;
      issue(1'b1, 8'h40, 32'hA1A1A1A1, 4'hF, rd, wr, rda, wra, wrd, wt);
      issue(1'b1, 8'h44, 32'hB2B2B2B2, 4'hF, rd, wr, rda, wra, wrd, wt);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h48;
      req_wdata = 32'hC3C3C3C3; req_be = 4'hF;
      to_neg(); chk("bp_full_ready_a", {31'b0, req_ready}, 32'd0);
      chk("bp_full_wr_en", {31'b0, ram_wr_en}, 32'd0); to_pos();
      to_neg(); chk("bp_full_ready_b", {31'b0, req_ready}, 32'd0); to_pos();
      resp_ready = 1'b1;
      to_neg(); chk("bp_pop_ready", {31'b0, req_ready}, 32'd0); to_pos();
      resp_ready = 1'b0;
      issue(1'b1, 8'h48, 32'hC3C3C3C3, 4'hF, rd, wr, rda, wra, wrd, wt);
      chk("bp_third_wait", 32'(wt), 32'd0);
      to_neg(); chk("bp_refull_ready", {31'b0, req_ready}, 32'd0); to_pos();
      resp_ready = 1'b1;
      idle(4);
      issue(1'b0, 8'h40, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      issue(1'b0, 8'h44, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      issue(1'b0, 8'h48, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      idle(3);

      // Zero byte-enable write leaves the bank untouched
      issue(1'b1, 8'h20, 32'h11223344, 4'hF, rd, wr, rda, wra, wrd, wt);
      issue(1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, rd, wr, rda, wra, wrd, wt);
      chk("be0_rd_en", {31'b0, rd}, 32'd0);
      chk("be0_wr_en", {31'b0, wr}, 32'd0);
      to_neg(); chk("be0_next_wr_en", {31'b0, ram_wr_en}, 32'd0); to_pos();
      issue(1'b0, 8'h20, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      idle(3);

      // Reset during RMW_WAIT drops the pending merge write
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10;
      req_wdata = 32'h0000CC00; req_be = 4'b0010;
      to_neg();
      chk("rst_rmw_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rmw_rd_en", {31'b0, ram_rd_en}, 32'd1);
      to_pos();
      req_valid = 1'b0;
      rst = 1'b1;
      to_neg();
      chk("rst_mid_wr_en", {31'b0, ram_wr_en}, 32'd0);
      chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_mid_idle_ready", {31'b0, req_ready}, 32'd1);
      to_pos();
      rst = 1'b0;
      idle(1);
      issue(1'b0, 8'h10, 32'h0, 4'h0, rd, wr, rda, wra, wrd, wt);
      idle(4);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
